// File: rtl/rib_pkg.sv
// Shared definitions for the RIB DMA copy engine: FSM encoding and
// RIB request field constants.
package rib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DONE   = 3'd5
  } rib_state_e;

  localparam logic [3:0]  RIB_MASK_WORD  = 4'b1111;
  localparam logic        RIB_WR         = 1'b1;
  localparam logic        RIB_RD         = 1'b0;
  localparam logic [31:0] RIB_WORD_BYTES = 32'd4;

endpackage

// File: rtl/rib_dma.sv
// Word-copy DMA over a single-outstanding RIB initiator port.
// Optional macro RIB_DMA_IRQ_EN adds a sticky completion interrupt (o_irq / i_irq_clr).
module rib_dma
  import rib_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int ADDR_ALIGN = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
`ifdef RIB_DMA_IRQ_EN
  input  logic             i_irq_clr,
  output logic             o_irq,
`endif
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_ribm_addr,
  output logic             o_ribm_wrcs,
  output logic [3:0]       o_ribm_mask,
  output logic [31:0]      o_ribm_wdata,
  input  logic [31:0]      i_ribm_rdata,
  output logic             o_ribm_req,
  input  logic             i_ribm_gnt,
  input  logic             i_ribm_rsp,
  output logic             o_ribm_rdy
);

  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ADDR_ALIGN) - 32'd1);

  rib_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // Bus outputs decode purely from state so reset clears them immediately.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    data_d       = data_q;
    rem_d        = rem_q;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_ribm_req   = 1'b0;
    o_ribm_rdy   = 1'b0;
    o_ribm_wrcs  = RIB_RD;
    o_ribm_mask  = '0;
    o_ribm_addr  = '0;
    o_ribm_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_len != '0) begin
            src_d   = i_src_addr & ALIGN_MASK;
            dst_d   = i_dst_addr & ALIGN_MASK;
            rem_d   = i_len;
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_REQ: begin
        o_ribm_req  = 1'b1;
        o_ribm_wrcs = RIB_RD;
        o_ribm_mask = RIB_MASK_WORD;
        o_ribm_addr = src_q & ALIGN_MASK;
        if (i_ribm_gnt) state_d = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        o_ribm_rdy = 1'b1;
        if (i_ribm_rsp) begin
          data_d  = i_ribm_rdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        o_ribm_req   = 1'b1;
        o_ribm_wrcs  = RIB_WR;
        o_ribm_mask  = RIB_MASK_WORD;
        o_ribm_addr  = dst_q & ALIGN_MASK;
        o_ribm_wdata = data_q;
        if (i_ribm_gnt) state_d = ST_WR_RSP;
      end
      ST_WR_RSP: begin
        o_ribm_rdy = 1'b1;
        if (i_ribm_rsp) begin
          // 32-bit adds wrap naturally past 0xFFFFFFFC.
          src_d   = src_q + RIB_WORD_BYTES;
          dst_d   = dst_q + RIB_WORD_BYTES;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef RIB_DMA_IRQ_EN
  logic irq_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      irq_q <= 1'b0;
    end else if (i_irq_clr) begin
      irq_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      irq_q <= 1'b1;
    end
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_rib_dma.sv
// Scoreboard bench for rib_dma: a reactive RIB responder with programmable
// wait states, an address-list reference model, and a decoupled bus monitor.
module tb_rib_dma;

  localparam int LEN_W = 16;

  logic             clk;
  logic             rstn;
  logic             i_start;
  logic [31:0]      i_src_addr;
  logic [31:0]      i_dst_addr;
  logic [LEN_W-1:0] i_len;
  logic             o_busy;
  logic             o_done;
  logic [31:0]      o_ribm_addr;
  logic             o_ribm_wrcs;
  logic [3:0]       o_ribm_mask;
  logic [31:0]      o_ribm_wdata;
  logic [31:0]      i_ribm_rdata;
  logic             o_ribm_req;
  logic             i_ribm_gnt;
  logic             i_ribm_rsp;
  logic             o_ribm_rdy;
`ifdef RIB_DMA_IRQ_EN
  logic             i_irq_clr;
  logic             o_irq;
`endif

  rib_dma #(.LEN_W(LEN_W), .ADDR_ALIGN(2)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
`ifdef RIB_DMA_IRQ_EN
    .i_irq_clr    (i_irq_clr),
    .o_irq        (o_irq),
`endif
    .i_start      (i_start),
    .i_src_addr   (i_src_addr),
    .i_dst_addr   (i_dst_addr),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_ribm_addr  (o_ribm_addr),
    .o_ribm_wrcs  (o_ribm_wrcs),
    .o_ribm_mask  (o_ribm_mask),
    .o_ribm_wdata (o_ribm_wdata),
    .i_ribm_rdata (i_ribm_rdata),
    .o_ribm_req   (o_ribm_req),
    .i_ribm_gnt   (i_ribm_gnt),
    .i_ribm_rsp   (i_ribm_rsp),
    .o_ribm_rdy   (o_ribm_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%08h exp=%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Source memory contents: a fixed scramble of the byte address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- responder ----------------
  int   gnt_delay = 0;
  int   rsp_delay = 0;
  bit   spur_en   = 0;
  logic pend_q, pend_rd_q, spur_q, rsp_real;
  int   wcnt_q, rcnt_q;
  logic [31:0] raddr_q;

  assign i_ribm_gnt   = o_ribm_req && (wcnt_q >= gnt_delay);
  assign rsp_real     = pend_q && (rcnt_q >= rsp_delay);
  assign i_ribm_rsp   = rsp_real || (!pend_q && spur_q);
  assign i_ribm_rdata = rsp_real ? (pend_rd_q ? memfn(raddr_q) : 32'h0) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!rstn) begin
      pend_q <= 1'b0; pend_rd_q <= 1'b0; spur_q <= 1'b0;
      wcnt_q <= 0; rcnt_q <= 0; raddr_q <= '0;
    end else begin
      spur_q <= spur_en && ($urandom_range(0, 1) == 1);
      if (o_ribm_req && !i_ribm_gnt) wcnt_q <= wcnt_q + 1;
      else wcnt_q <= 0;
      if (o_ribm_req && i_ribm_gnt) begin
        pend_q    <= 1'b1;
        pend_rd_q <= !o_ribm_wrcs;
        raddr_q   <= o_ribm_addr;
        rcnt_q    <= 0;
      end else if (pend_q) begin
        if (i_ribm_rsp && o_ribm_rdy) pend_q <= 1'b0;
        else rcnt_q <= rcnt_q + 1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  xact_t       expq[$];
  int          wr_acc = 0;
  bit          hold_v = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_wrcs;
  logic [3:0]  hold_mask;

  always @(negedge clk) begin
    if (rstn) begin
      if (hold_v) begin
        chk("hold_req", 32'(o_ribm_req), 32'd1);
        chk("hold_addr", o_ribm_addr, hold_addr);
        chk("hold_wrcs", 32'(o_ribm_wrcs), 32'(hold_wrcs));
        chk("hold_mask", 32'(o_ribm_mask), 32'(hold_mask));
        chk("hold_wdata", o_ribm_wdata, hold_wdata);
      end
      hold_v     = o_ribm_req && !i_ribm_gnt;
      hold_addr  = o_ribm_addr;
      hold_wrcs  = o_ribm_wrcs;
      hold_mask  = o_ribm_mask;
      hold_wdata = o_ribm_wdata;
      if (o_ribm_req && i_ribm_gnt) begin
        if (expq.size() == 0) begin
          chk("unexpected_req", 32'(o_ribm_addr), 32'hFFFF_FFFF);
        end else begin
          xact_t e;
          e = expq.pop_front();
          chk(e.wr ? "wr_wrcs" : "rd_wrcs", 32'(o_ribm_wrcs), 32'(e.wr));
          chk(e.wr ? "wr_addr" : "rd_addr", o_ribm_addr, e.addr);
          chk("mask", 32'(o_ribm_mask), 32'hF);
          if (e.wr) chk("wr_data", o_ribm_wdata, e.data);
        end
        if (o_ribm_wrcs) wr_acc++;
      end
      if (o_done) chk("done_words_left", 32'(expq.size()), 32'd0);
    end else begin
      hold_v = 0;
    end
  end

  // Reference model: a transfer is just the interleaved list of read and write addresses.
  task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input int len);
    logic [31:0] sa, da;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      expq.push_back('{wr: 1'b0, addr: sa + 32'(4 * i), data: 32'h0});
      expq.push_back('{wr: 1'b1, addr: da + 32'(4 * i), data: memfn(sa + 32'(4 * i))});
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int len);
    @(negedge clk);
    i_src_addr = s;
    i_dst_addr = d;
    i_len      = LEN_W'(len);
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  // exp_lat < 0 skips the latency comparison (non-zero-wait responder).
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                          input int exp_lat, input bit ign_start, input bit clr_on_done);
    int n;
    push_expect(s, d, len);
    pulse_start(s, d, len);
    n = 1;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    while (!o_done && n < 3000) begin
      if (ign_start && $urandom_range(0, 5) == 0) begin
        i_start    = 1'b1;
        i_src_addr = $urandom;
        i_dst_addr = $urandom;
        i_len      = LEN_W'($urandom_range(0, 9));
      end
      @(negedge clk);
      i_start = 1'b0;
      n++;
    end
    if (!o_done) chk("done_timeout", 32'd0, 32'd1);
    else if (exp_lat >= 0) chk("done_latency", 32'(n), 32'(exp_lat));
`ifdef RIB_DMA_IRQ_EN
    if (clr_on_done) i_irq_clr = 1'b1;
`else
    if (clr_on_done) n = 0;
`endif
    @(negedge clk);
`ifdef RIB_DMA_IRQ_EN
    i_irq_clr = 1'b0;
`endif
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_after_done", 32'(o_busy), 32'd0);
    $display("xfer src=%08h dst=%08h len=%0d cycles=%0d", s, d, len, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_req"}, 32'(o_ribm_req), 32'd0);
    chk({tag, "_rdy"}, 32'(o_ribm_rdy), 32'd0);
    chk({tag, "_wrcs"}, 32'(o_ribm_wrcs), 32'd0);
    chk({tag, "_mask"}, 32'(o_ribm_mask), 32'd0);
    chk({tag, "_addr"}, o_ribm_addr, 32'd0);
    chk({tag, "_wdata"}, o_ribm_wdata, 32'd0);
  endtask

  initial begin
    int base, n;
    rstn = 1'b0; i_start = 1'b0; i_src_addr = '0; i_dst_addr = '0; i_len = '0;
`ifdef RIB_DMA_IRQ_EN
    i_irq_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Zero-wait directed cases: basic copy, empty copy, address wrap.
    run_xfer(32'h0000_0100, 32'h0000_0200, 3, 13, 0, 0);
    run_xfer(32'h0000_0300, 32'h0000_0400, 0, 1, 0, 0);
    run_xfer(32'hFFFF_FFFC, 32'h0000_1000, 2, 9, 0, 0);
    // Slow grant and slow response: fields must hold until accepted.
    gnt_delay = 5; rsp_delay = 3;
    run_xfer(32'h0000_2000, 32'h0000_3000, 2, -1, 0, 0);
    // Stray responses in request states must be ignored.
    gnt_delay = 0; rsp_delay = 0; spur_en = 1;
    run_xfer(32'h0000_0040, 32'h0000_0083, 3, 13, 1, 0);

    for (int k = 0; k < 8; k++) begin
      gnt_delay = $urandom_range(0, 3);
      rsp_delay = $urandom_range(0, 3);
      spur_en   = ($urandom_range(0, 1) == 1);
      n = $urandom_range(1, 6);
      run_xfer($urandom, $urandom, n,
               (gnt_delay == 0 && rsp_delay == 0) ? 4 * n + 1 : -1, 1, 0);
    end

    // Reset during the second write response of a 4-word copy.
    gnt_delay = 0; rsp_delay = 2; spur_en = 0;
    base = wr_acc;
    push_expect(32'h0000_0700, 32'h0000_0800, 4);
    pulse_start(32'h0000_0700, 32'h0000_0800, 4);
    n = 0;
    while (!(wr_acc == base + 2 && o_ribm_rdy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_rsp2", 32'(o_ribm_rdy), 32'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    expq.delete();
    repeat (2) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(o_done), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 32'(o_busy), 32'd0);
    chk("no_done_after_release", 32'(o_done), 32'd0);
    rsp_delay = 0;
    run_xfer(32'h0000_0500, 32'h0000_0600, 2, 9, 0, 0);

`ifdef RIB_DMA_IRQ_EN
    chk("irq_set", 32'(o_irq), 32'd1);
    i_irq_clr = 1'b1;
    @(negedge clk);
    i_irq_clr = 1'b0;
    chk("irq_cleared", 32'(o_irq), 32'd0);
    run_xfer(32'h0000_0900, 32'h0000_0A00, 1, 5, 0, 1);
    chk("irq_clr_wins", 32'(o_irq), 32'd0);
`endif

    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rib_dma.md
RIB_DMA -- requirements
Module: rib_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-002 SHALL have parameter ADDR_ALIGN, default 2, number of forced-zero low address bits (word aligned).
REQ-003 SHALL have port i_clk  input  1  sole clock, all flops rise-edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  one-cycle start pulse, sampled only in IDLE.
REQ-006 SHALL have ports i_src_addr / i_dst_addr  input  32  copy source and destination byte addresses.
REQ-007 SHALL have port i_len  input  LEN_W  number of 32-bit words to copy.
REQ-008 SHALL have ports o_busy  output  1  (high from start until done) and o_done  output  1  (one-cycle completion pulse).
REQ-009 SHALL have RIB initiator ports o_ribm_addr out 32, o_ribm_wrcs out 1 (1=write), o_ribm_mask out 4, o_ribm_wdata out 32, i_ribm_rdata in 32, o_ribm_req out 1, i_ribm_gnt in 1, i_ribm_rsp in 1, o_ribm_rdy out 1.

Function
REQ-010 SHALL treat a request as accepted on a rising edge where o_ribm_req and i_ribm_gnt are both high; req and all request fields held stable until accepted.
REQ-011 SHALL treat a response as complete on a rising edge where i_ribm_rsp and o_ribm_rdy are both high; at most one transaction outstanding.
REQ-012 SHALL implement FSM states IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, DONE.
REQ-013 IDLE: i_start with i_len!=0 latches src, dst, len, goes RD_REQ next cycle; i_start with i_len==0 goes DONE with no bus traffic.
REQ-014 RD_REQ: drive req=1, wrcs=0, mask=4'b1111, addr=src; on accept go RD_RSP.
REQ-015 RD_RSP: rdy=1; on response capture i_ribm_rdata into data register, go WR_REQ.
REQ-016 WR_REQ: drive req=1, wrcs=1, mask=4'b1111, addr=dst, wdata=captured data; on accept go WR_RSP.
REQ-017 WR_RSP: rdy=1; on response src+=4, dst+=4, remaining-=1; remaining reaching 0 goes DONE, else RD_REQ.
REQ-018 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-019 o_busy SHALL be high in every state except IDLE.
REQ-020 Address increment SHALL be modulo 2^32 (0xFFFFFFFC+4 wraps to 0x00000000); low ADDR_ALIGN bits of o_ribm_addr forced to 0.
REQ-021 i_start while busy SHALL be ignored; no queuing.
REQ-022 o_ribm_req SHALL be low and o_ribm_rdy low in IDLE, DONE and both RSP states / both REQ states respectively.
REQ-023 A response arriving in a REQ state (protocol violation) SHALL be ignored.
REQ-024 Minimum per-word cost with a zero-wait responder (gnt=req, rsp one cycle later): 4 cycles; start-to-first-req latency 1 cycle.

Reset
REQ-025 On i_rstn low, immediately: state IDLE, o_busy=0, o_done=0, o_ribm_req=0, o_ribm_rdy=0, o_ribm_wrcs=0, o_ribm_mask=0, addr/wdata/counters=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer with no completion pulse; first cycle after release is IDLE.

Configuration
REQ-027 Macro RIB_DMA_IRQ_EN defined: adds o_irq output 1 (sticky, set on DONE, cleared by new input i_irq_clr input 1; clear wins over simultaneous set) ; reset 0.
REQ-028 Macro RIB_DMA_IRQ_EN undefined: o_irq and i_irq_clr absent, behaviour otherwise identical.

Structure
REQ-029 Shared package rib_pkg SHALL hold FSM state encoding, RIB_MASK_WORD (4'b1111), RIB_WR/RIB_RD wrcs constants.
REQ-030 Single module, no sub-module; FSM and datapath in rib_dma.

Verification
REQ-031 src=0x100, dst=0x200, len=3, zero-wait responder -> reads 0x100/104/108, writes 0x200/204/208 with read data, o_done at cycle 13 after start.
REQ-032 len=0 start -> o_done one cycle after start, o_ribm_req never asserted.
REQ-033 Responder holds gnt low 5 cycles and rsp delayed 3 cycles -> request fields stable throughout, data copied correctly.
REQ-034 src=0xFFFFFFFC, len=2 -> second read address 0x00000000.
REQ-035 Assert i_rstn low during WR_RSP of word 2 of len=4 -> all outputs 0 at once, no o_done; new start after release runs normally.
REQ-036 With RIB_DMA_IRQ_EN: i_irq_clr asserted in the DONE cycle -> o_irq stays 0; without clr -> o_irq 1 until clr.
